// File: rtl/cacheline_burst_bridge.sv
// Round-robin bridge from CHANNELS line-wide requesters to one beat-wide burst memory port.
// Optional macro BRIDGE_RADDR_CHECK_EN: flag read beats whose return address differs from the line address.
module cacheline_burst_bridge #(
  parameter int CHANNELS   = 2,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ufp_addr  [CHANNELS],
  input  logic [CHANNELS-1:0]   ufp_read,
  input  logic [CHANNELS-1:0]   ufp_write,
  input  logic [LINE_WIDTH-1:0] ufp_wdata [CHANNELS],
  output logic [LINE_WIDTH-1:0] ufp_rdata [CHANNELS],
  output logic [CHANNELS-1:0]   ufp_resp,
  output logic [31:0]           dfp_addr,
  output logic                  dfp_read,
  output logic                  dfp_write,
  output logic [BEAT_WIDTH-1:0] dfp_wdata,
  input  logic                  dfp_ready,
  input  logic [31:0]           dfp_raddr,
  input  logic [BEAT_WIDTH-1:0] dfp_rdata,
  input  logic                  dfp_rvalid,
  output logic                  error,
  output logic [2:0]            dbg_state_o
);
  localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BK          = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_COLLECT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [CW-1:0]         gnt_q, gnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [BK-1:0]         beat_q, beat_d;
  logic [LINE_WIDTH-1:0] rdata_q [CHANNELS];
  logic                  rdata_we;
  logic                  found;
  logic [CW-1:0]         pick;
  int                    idx;
  logic                  err_set;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    line_d   = line_q;
    beat_d   = beat_q;
    rdata_we = 1'b0;
    err_set  = 1'b0;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    // Scan from the priority pointer so the first requester found wins.
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(rr_q) + k) % CHANNELS;
      if (!found && (ufp_read[idx] || ufp_write[idx])) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d  = pick;
          rr_d   = (int'(pick) == CHANNELS - 1) ? '0 : pick + CW'(1);
          addr_d = {ufp_addr[pick][31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          beat_d = '0;
          if (ufp_write[pick]) begin
            line_d  = ufp_wdata[pick];
            state_d = WR_BURST;
          end else begin
            state_d = RD_CMD;
          end
        end
      end
      WR_BURST: begin
        if (dfp_ready) begin
          if (beat_q == BK'(BEATS - 1)) state_d = RESP;
          else                          beat_d  = beat_q + BK'(1);
        end
      end
      RD_CMD: begin
        if (dfp_ready) begin
          beat_d  = '0;
          state_d = RD_COLLECT;
        end
      end
      RD_COLLECT: begin
        if (dfp_rvalid) begin
          line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = dfp_rdata;
          err_set = (dfp_raddr != addr_q);
          if (beat_q == BK'(BEATS - 1)) begin
            rdata_we = 1'b1;
            state_d  = RESP;
          end else begin
            beat_d = beat_q + BK'(1);
          end
        end
      end
      RESP: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) rdata_q[c] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      if (rdata_we) rdata_q[gnt_q] <= line_d;
    end
  end

  // All downstream outputs decode from registers only, so they never see dfp_ready combinationally.
  always_comb begin
    dfp_write = (state_q == WR_BURST);
    dfp_read  = (state_q == RD_CMD);
    dfp_addr  = (dfp_write || dfp_read) ? addr_q : '0;
    dfp_wdata = dfp_write ? line_q[beat_q*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ufp_resp[c]  = (state_q == RESP) && (int'(gnt_q) == c);
      ufp_rdata[c] = rdata_q[c];
    end
  end

  assign dbg_state_o = state_q;

`ifdef BRIDGE_RADDR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Line-offset address bits are discarded by design; fold them away explicitly.
  logic unused_bits;
  always_comb begin
    unused_bits = err_set ^ (^dfp_raddr);
    for (int c = 0; c < CHANNELS; c++) unused_bits = unused_bits ^ (^ufp_addr[c][OFFSET_BITS-1:0]);
  end
endmodule

// File: tb/tb_cacheline_burst_bridge.sv
// Directed bench for cacheline_burst_bridge: transaction-level model, per-cycle compare, memory responder.
module tb_cacheline_burst_bridge;
  localparam int CH   = 2;
  localparam int LW   = 256;
  localparam int BW   = 64;
  localparam int NB   = LW / BW;
  localparam int OFF  = $clog2(LW / 8);

  // Valid/ready: a command or write beat transfers on a rising edge where the bridge drives
  // dfp_read/dfp_write high and dfp_ready is high; read beats transfer whenever dfp_rvalid is high.

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   ufp_addr  [CH];
  logic [CH-1:0] ufp_read  = '0;
  logic [CH-1:0] ufp_write = '0;
  logic [LW-1:0] ufp_wdata [CH];
  logic [LW-1:0] ufp_rdata [CH];
  logic [CH-1:0] ufp_resp;
  logic [31:0]   dfp_addr;
  logic          dfp_read, dfp_write;
  logic [BW-1:0] dfp_wdata;
  logic          dfp_ready = 1'b1;
  logic [31:0]   dfp_raddr = '0;
  logic [BW-1:0] dfp_rdata = '0;
  logic          dfp_rvalid = 1'b0;
  logic          error;
  logic [2:0]    dbg_state;

  cacheline_burst_bridge #(.CHANNELS(CH), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_read(ufp_read), .ufp_write(ufp_write), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
    .dfp_ready(dfp_ready), .dfp_raddr(dfp_raddr), .dfp_rdata(dfp_rdata), .dfp_rvalid(dfp_rvalid),
    .error(error), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            ch;
    bit            wr;
    logic [31:0]   addr;
    logic [LW-1:0] line;
  } tr_t;

  tr_t           exp_tr_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] seen_q[$];
  bit            ready_q[$];
  logic [LW-1:0] last_rdata [CH];
  logic [BW-1:0] rd_beats [NB];
  logic [31:0]   last_waddr = '0;
  int total = 0;
  int bad = 0;
  int beat_k = 0;
  int cmd_cnt = 0;
  int cmd_taken = 0;
  logic [31:0] cmd_addr = '0;
  int rd_lat = 4;
  int bad_beat = -1;
  int beats_sent = 0;
  bit collecting = 0;
  logic [31:0] col_addr = '0;
  bit exp_err = 0;
  bit rst_seen = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~((32'd1 << OFF) - 32'd1);
  endfunction

  function automatic logic [LW-1:0] line_from_beats();
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = rd_beats[k];
    return l;
  endfunction

  task automatic push_tr(input int ch, input bit wr, input logic [31:0] addr, input logic [LW-1:0] line);
    tr_t t;
    t.ch = ch; t.wr = wr; t.addr = align(addr); t.line = line;
    exp_tr_q.push_back(t);
    if (wr) for (int k = 0; k < NB; k++) exp_q.push_back(line[k*BW +: BW]);
  endtask

  task automatic do_req(input int ch, input bit wr, input logic [31:0] addr,
                        input logic [LW-1:0] wd, output int n);
    @(posedge clk); #1;
    ufp_addr[ch]  = addr;
    ufp_wdata[ch] = wd;
    if (wr) ufp_write[ch] = 1'b1; else ufp_read[ch] = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (ufp_resp[ch]) break;
    end
    ufp_read[ch]  = 1'b0;
    ufp_write[ch] = 1'b0;
    chk("req_done", ufp_resp[ch], 1'b1);
  endtask

  // Compare process: checks every visible output against the transaction model each cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_tr_q.delete(); exp_q.delete();
      for (int c = 0; c < CH; c++) last_rdata[c] = '0;
      beat_k = 0; collecting = 0; exp_err = 0; rst_seen = 1;
    end else begin
      if (rst_seen) begin
        chk("rst_dfp_addr", dfp_addr, 0);
        chk("rst_dfp_wdata", dfp_wdata, 0);
        chk("rst_dfp_cmd", {dfp_read, dfp_write}, 0);
        chk("rst_resp", ufp_resp, 0);
        rst_seen = 0;
      end
      chk("rd_wr_excl", dfp_read & dfp_write, 0);
      if (dfp_write) begin
        if (exp_tr_q.size() == 0 || exp_q.size() == 0) chk("wr_unexpected", dfp_write, 0);
        else begin
          chk("wr_is_write", exp_tr_q[0].wr, 1'b1);
          chk("wr_addr", dfp_addr, exp_tr_q[0].addr);
          chk("wr_beat", dfp_wdata, exp_q[0]);
          if (dfp_ready) begin
            void'(exp_q.pop_front());
            seen_q.push_back(dfp_wdata);
            last_waddr = dfp_addr;
            beat_k++;
          end
        end
      end
      if (dfp_read) begin
        if (exp_tr_q.size() == 0) chk("rd_unexpected", dfp_read, 0);
        else begin
          chk("rd_is_read", exp_tr_q[0].wr, 1'b0);
          chk("rd_addr", dfp_addr, exp_tr_q[0].addr);
          if (dfp_ready) begin
            cmd_addr = dfp_addr; cmd_cnt++;
            collecting = 1; col_addr = dfp_addr;
          end
        end
      end
`ifdef BRIDGE_RADDR_CHECK_EN
      chk("error", error, exp_err);
      if (collecting && dfp_rvalid && dfp_raddr != col_addr) exp_err = 1;
`else
      chk("error", error, 1'b0);
`endif
      if (|ufp_resp) begin
        if (exp_tr_q.size() == 0) chk("resp_unexpected", ufp_resp, 0);
        else begin
          tr_t t;
          logic [CH-1:0] e;
          t = exp_tr_q.pop_front();
          e = '0; e[t.ch] = 1'b1;
          chk("resp_chan", ufp_resp, e);
          if (t.wr) chk("resp_after_beats", beat_k, NB);
          else last_rdata[t.ch] = t.line;
        end
        beat_k = 0; collecting = 0;
      end
      for (int c = 0; c < CH; c++) chk("rdata", ufp_rdata[c], last_rdata[c]);
    end
  end

  // Ready driver: consumes a pattern while the bridge is offering a command/beat, else ready.
  initial begin
    forever begin
      @(posedge clk); #1;
      if ((dfp_write || dfp_read) && ready_q.size() > 0) dfp_ready = ready_q.pop_front();
      else dfp_ready = 1'b1;
    end
  end

  // Memory responder: after rd_lat cycles returns NB beats back to back.
  initial begin
    int   lat_cnt;
    int   rd_k;
    bit   rd_busy;
    logic [31:0] rd_addr_cur;
    lat_cnt = 0; rd_k = 0; rd_busy = 0; rd_addr_cur = '0;
    forever begin
      @(posedge clk); #1;
      dfp_rvalid = 1'b0;
      if (cmd_cnt != cmd_taken) begin
        cmd_taken = cmd_cnt;
        rd_busy = 1; rd_k = 0; lat_cnt = rd_lat; rd_addr_cur = cmd_addr;
      end else if (rd_busy) begin
        if (lat_cnt > 0) lat_cnt--;
        else begin
          dfp_rvalid = 1'b1;
          dfp_rdata  = rd_beats[rd_k];
          dfp_raddr  = (rd_k == bad_beat) ? 32'hDEAD_0000 : rd_addr_cur;
          rd_k++; beats_sent++;
          if (rd_k == NB) rd_busy = 0;
        end
      end
    end
  end

  initial begin
    int n;
    int cnt [CH];
    int order [6];
    int oi;
    logic [LW-1:0] l0, l1;
    for (int c = 0; c < CH; c++) begin ufp_addr[c] = '0; ufp_wdata[c] = '0; cnt[c] = 0; end
    for (int k = 0; k < NB; k++) rd_beats[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write on channel 0 with an unaligned address.
    seen_q.delete();
    l0 = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2, 64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
    push_tr(0, 1, 32'h1000_0014, l0);
    do_req(0, 1, 32'h1000_0014, l0, n);
    chk("wr_latency", n, 6);
    chk("wr_nbeats", seen_q.size(), 4);
    if (seen_q.size() == 4) begin
      chk("wr_b0", seen_q[0], 64'hA0A0A0A0A0A0A0A0);
      chk("wr_b3", seen_q[3], 64'hA3A3A3A3A3A3A3A3);
    end
    chk("wr_addr_lit", last_waddr, 32'h1000_0000);

    // Read on channel 1, memory latency 10.
    rd_lat = 10;
    rd_beats[0] = 64'h1111111111111111; rd_beats[1] = 64'h2222222222222222;
    rd_beats[2] = 64'h3333333333333333; rd_beats[3] = 64'h4444444444444444;
    push_tr(1, 0, 32'h2000_0040, line_from_beats());
    do_req(1, 0, 32'h2000_0040, '0, n);
    chk("rd_line_lit", ufp_rdata[1],
        {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});
    @(negedge clk);
    chk("rd_resp_single", ufp_resp, 0);

    // Both channels request writes together, three each, held.
    l0 = {4{64'h0C0C_0000_0000_0C0C}};
    l1 = {4{64'h1D1D_0000_0000_1D1D}};
    for (int i = 0; i < 3; i++) begin
      push_tr(0, 1, 32'h0000_0100, l0);
      push_tr(1, 1, 32'h0000_0200, l1);
    end
    @(posedge clk); #1;
    ufp_addr[0] = 32'h0000_0100; ufp_wdata[0] = l0;
    ufp_addr[1] = 32'h0000_0200; ufp_wdata[1] = l1;
    ufp_write = 2'b11;
    oi = 0;
    for (int g = 0; g < 200 && (cnt[0] < 3 || cnt[1] < 3); g++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) if (ufp_resp[c]) begin
        if (oi < 6) order[oi] = c;
        oi++;
        cnt[c]++;
        if (cnt[c] == 3) ufp_write[c] = 1'b0;
      end
    end
    ufp_write = '0;
    chk("arb_count", oi, 6);
    if (oi == 6) for (int i = 0; i < 6; i++) chk("arb_order", order[i], i % 2);

    // Write with dfp_ready toggling.
    seen_q.delete();
    ready_q = '{1, 0, 0, 1, 1, 0, 1};
    l1 = {64'hD3D3000000000033, 64'hD2D2000000000022, 64'hD1D1000000000011, 64'hD0D0000000000000};
    push_tr(1, 1, 32'h3000_0020, l1);
    do_req(1, 1, 32'h3000_0020, l1, n);
    chk("toggle_nbeats", seen_q.size(), 4);
    chk("toggle_pattern_used", ready_q.size(), 0);
    ready_q.delete();

    // Reset during read collection after two beats.
    rd_lat = 3; beats_sent = 0;
    for (int k = 0; k < NB; k++) rd_beats[k] = {32'h5A5A0000, 32'(k)};
    push_tr(0, 0, 32'h4000_0000, line_from_beats());
    @(posedge clk); #1;
    ufp_addr[0] = 32'h4000_0000; ufp_read[0] = 1'b1;
    for (int g = 0; g < 100 && beats_sent < 2; g++) begin @(posedge clk); #2; end
    chk("beats_before_rst", beats_sent, 2);
    @(posedge clk); #2;
    rst = 1'b1; ufp_read[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    rd_lat = 2;
    for (int k = 0; k < NB; k++) rd_beats[k] = {32'h7E7E0000, 32'(k + 8)};
    push_tr(0, 0, 32'h5000_003F, line_from_beats());
    do_req(0, 0, 32'h5000_003F, '0, n);
    chk("post_rst_line", ufp_rdata[0],
        {64'h7E7E00000000000B, 64'h7E7E00000000000A, 64'h7E7E000000000009, 64'h7E7E000000000008});

`ifdef BRIDGE_RADDR_CHECK_EN
    bad_beat = 1; rd_lat = 2;
    push_tr(1, 0, 32'h6000_0000, line_from_beats());
    do_req(1, 0, 32'h6000_0000, '0, n);
    chk("err_set", error, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("err_sticky", error, 1'b1);
    bad_beat = -1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", error, 1'b0);
`endif

    repeat (4) @(posedge clk);
    chk("all_resp_seen", exp_tr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
